// File: rtl/instr_fetch_unit_pkg.sv
// Shared types, widths and helpers for the instruction fetch unit and its skid buffer.
// Field positions follow the instruction word layout {opcode, op_a, op_b}.
package instr_fetch_unit_pkg;

   localparam int PC_W     = 8;
   localparam int INSTR_W  = 18;
   localparam int PROG_LEN = 8;
   localparam int ENTRY_W  = PC_W + INSTR_W;

   localparam int OPC_HI = 17;
   localparam int OPC_LO = 16;
   localparam int A_HI   = 15;
   localparam int A_LO   = 8;
   localparam int B_HI   = 7;
   localparam int B_LO   = 0;

   typedef enum logic [1:0] {
      OPC_0 = 2'd0,
      OPC_1 = 2'd1,
      OPC_2 = 2'd2,
      OPC_3 = 2'd3
   } opcode_e;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Sequential successor with wrap at the end of the program image.
   function automatic logic [PC_W-1:0] pc_succ(input logic [PC_W-1:0] pc_v);
      logic [PC_W-1:0] nxt;
      if (32'(pc_v) == (PROG_LEN - 32'd1)) begin
         nxt = {PC_W{1'b0}};
      end else begin
         nxt = pc_v + PC_W'(1);
      end
      return nxt;
   endfunction

   // Out-of-range jump targets restart the program from address 0.
   function automatic logic [PC_W-1:0] pc_clamp(input logic [PC_W-1:0] pc_v);
      logic [PC_W-1:0] res;
      if (32'(pc_v) >= PROG_LEN) begin
         res = {PC_W{1'b0}};
      end else begin
         res = pc_v;
      end
      return res;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry {pc, instr} FIFO between the fetch port and the execute handshake.
// The head entry is a register so execute never sees a combinational path from instr.
module fetch_skid_buf
   import instr_fetch_unit_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_entry,
   input  logic               pop,
   output logic [ENTRY_W-1:0] head,
   output logic               valid,
   output logic [1:0]         cnt
);

   fetch_entry_t ent0_r;
   fetch_entry_t ent1_r;
   fetch_entry_t ent0_nxt_s;
   fetch_entry_t ent1_nxt_s;
   fetch_entry_t push_e_s;
   logic [1:0]   cnt_r;
   logic [1:0]   cnt_nxt_s;
   logic         valid_r;
   logic         pop_s;

   assign push_e_s = fetch_entry_t'(push_entry);

   // Next-state of both entries and the occupancy count.
   always_comb begin
      ent0_nxt_s = ent0_r;
      ent1_nxt_s = ent1_r;
      cnt_nxt_s  = cnt_r;
      pop_s      = pop & (cnt_r != 2'd0);
      if (flush) begin
         ent0_nxt_s = '0;
         ent1_nxt_s = '0;
         cnt_nxt_s  = 2'd0;
      end else begin
         case ({push, pop_s})
            2'b10: begin
               if (cnt_r == 2'd0) begin
                  ent0_nxt_s = push_e_s;
                  cnt_nxt_s  = 2'd1;
               end else if (cnt_r == 2'd1) begin
                  ent1_nxt_s = push_e_s;
                  cnt_nxt_s  = 2'd2;
               end else begin
                  cnt_nxt_s = cnt_r;
               end
            end
            2'b01: begin
               ent0_nxt_s = ent1_r;
               cnt_nxt_s  = cnt_r - 2'd1;
            end
            2'b11: begin
               if (cnt_r == 2'd1) begin
                  ent0_nxt_s = push_e_s;
               end else begin
                  ent0_nxt_s = ent1_r;
                  ent1_nxt_s = push_e_s;
               end
            end
            default: begin
               cnt_nxt_s = cnt_r;
            end
         endcase
      end
   end

   // Entry, count and valid registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ent0_r  <= '0;
         ent1_r  <= '0;
         cnt_r   <= 2'd0;
         valid_r <= 1'b0;
      end else begin
         ent0_r  <= ent0_nxt_s;
         ent1_r  <= ent1_nxt_s;
         cnt_r   <= cnt_nxt_s;
         valid_r <= (cnt_nxt_s != 2'd0);
      end
   end

   assign head  = ENTRY_W'(ent0_r);
   assign valid = valid_r;
   assign cnt   = cnt_r;

endmodule

// File: rtl/instr_fetch_unit_chk.sv
// Invariant checks for the fetch buffer: it never overflows and never captures when full.
module instr_fetch_unit_chk (
   input logic       clk,
   input logic       reset,
   input logic       push,
   input logic       flush,
   input logic [1:0] cnt
);

   a_no_full_capture: assert property (@(posedge clk) disable iff (reset)
      !(push && !flush && (cnt == 2'd2)))
      else $error("fetch buffer captured while full");

   a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
      cnt != 2'd3)
      else $error("fetch buffer count out of range");

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the pc, issues reads to instruction memory, buffers the returned
// words and presents decoded fields to execute over a valid/ready handshake.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   output logic [PC_W-1:0]    pc,
   input  logic [INSTR_W-1:0] instr,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [1:0]         opcode,
   output logic [7:0]         op_a,
   output logic [7:0]         op_b
);

   logic [PC_W-1:0]    pc_r;
   logic               inflight_r;
   logic [PC_W-1:0]    inflight_pc_r;
   logic               capture_s;
   logic               pop_s;
   logic               issue_s;
   logic [2:0]         cnt_next_s;
   logic [1:0]         buf_cnt_s;
   logic               buf_valid_s;
   logic [ENTRY_W-1:0] head_s;
   logic [ENTRY_W-1:0] push_entry_s;
   fetch_entry_t       head_e_s;

   // Occupancy after this edge decides whether one more read may be put in flight.
   always_comb begin
      capture_s    = inflight_r;
      pop_s        = buf_valid_s & out_ready;
      push_entry_s = {inflight_pc_r, instr};
      cnt_next_s   = {1'b0, buf_cnt_s} + {2'b00, capture_s} - {2'b00, pop_s};
      if (run && !redirect_valid && (cnt_next_s < 3'd2)) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
   end

   // Program counter and in-flight tracking; redirect outranks issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r          <= {PC_W{1'b0}};
         inflight_r    <= 1'b0;
         inflight_pc_r <= {PC_W{1'b0}};
      end else if (redirect_valid) begin
         pc_r          <= pc_clamp(redirect_pc);
         inflight_r    <= 1'b0;
         inflight_pc_r <= inflight_pc_r;
      end else if (issue_s) begin
         pc_r          <= pc_succ(pc_r);
         inflight_r    <= 1'b1;
         inflight_pc_r <= pc_r;
      end else begin
         pc_r          <= pc_r;
         inflight_r    <= 1'b0;
         inflight_pc_r <= inflight_pc_r;
      end
   end

   fetch_skid_buf u_buf (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_valid),
      .push       (capture_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .head       (head_s),
      .valid      (buf_valid_s),
      .cnt        (buf_cnt_s)
   );

   instr_fetch_unit_chk u_chk (
      .clk   (clk),
      .reset (reset),
      .push  (capture_s),
      .flush (redirect_valid),
      .cnt   (buf_cnt_s)
   );

   assign head_e_s  = fetch_entry_t'(head_s);
   assign pc        = pc_r;
   assign out_valid = buf_valid_s;
   assign out_pc    = head_e_s.pc;
   assign opcode    = head_e_s.instr[OPC_HI:OPC_LO];
   assign op_a      = head_e_s.instr[A_HI:A_LO];
   assign op_b      = head_e_s.instr[B_HI:B_LO];

endmodule
